// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, fetches one word per instruction over
// the imem req/ack handshake and issues it with its PC under valid/ready.
// Optional illegal-encoding check: define IF_ILLEGAL_CHECK_EN.
module instr_fetch #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          IMEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [31:0] idata_o,
    output logic [31:0] pc_o,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_target_i,
    output logic        fault_o,
    output logic [1:0]  fault_cause_o
);

    // A zero timeout disables the watchdog; keep the counter at least 1 bit wide.
    localparam int CW = (IMEM_TIMEOUT > 0) ? $clog2(IMEM_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'((IMEM_TIMEOUT > 0) ? IMEM_TIMEOUT - 1 : 0);

`ifdef IF_ILLEGAL_CHECK_EN
    localparam bit ILLEGAL_CHECK = 1'b1;
`else
    localparam bit ILLEGAL_CHECK = 1'b0;
`endif

    localparam logic [1:0] CAUSE_NONE      = 2'd0;
    localparam logic [1:0] CAUSE_TIMEOUT   = 2'd1;
    localparam logic [1:0] CAUSE_MISALIGN  = 2'd2;
    localparam logic [1:0] CAUSE_ILLEGAL   = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_ISSUE = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [31:0]     pc_q, pc_d;
    logic [31:0]     ir_q, ir_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      cause_q, cause_d;

    // State register; reset is asynchronous so outputs drop the instant rst rises.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            ir_q    <= 32'h0;
            cnt_q   <= '0;
            cause_q <= CAUSE_NONE;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            cnt_q   <= cnt_d;
            cause_q <= cause_d;
        end
    end

    // Next-state logic: fetch, issue, redirect and fault detection.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        cnt_d   = cnt_q;
        cause_d = cause_q;
        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
                cnt_d   = '0;
            end
            S_FETCH: begin
                if (imem_ack_i) begin
                    ir_d    = imem_rdata_i;
                    cnt_d   = '0;
                    // The word is still captured so it can be inspected after a fault.
                    if (ILLEGAL_CHECK && (imem_rdata_i[1:0] != 2'b11)) begin
                        state_d = S_FAULT;
                        cause_d = CAUSE_ILLEGAL;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end else if (IMEM_TIMEOUT != 0) begin
                    // cnt_q counts completed ack-less cycles; the last allowed cycle is TO_LAST+1.
                    if (cnt_q == TO_LAST) begin
                        state_d = S_FAULT;
                        cause_d = CAUSE_TIMEOUT;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            S_ISSUE: begin
                if (ready_i) begin
                    cnt_d = '0;
                    if (branch_taken_i) begin
                        // Misaligned targets are kept in pc for debug visibility.
                        pc_d = branch_target_i;
                        if (branch_target_i[1:0] != 2'b00) begin
                            state_d = S_FAULT;
                            cause_d = CAUSE_MISALIGN;
                        end else begin
                            state_d = S_FETCH;
                        end
                    end else begin
                        pc_d    = pc_q + 32'd4;
                        state_d = S_FETCH;
                    end
                end
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are decoded from registered state only.
    always_comb begin
        imem_req_o    = (state_q == S_FETCH);
        imem_addr_o   = pc_q;
        valid_o       = (state_q == S_ISSUE);
        idata_o       = ir_q;
        pc_o          = pc_q;
        fault_o       = (state_q == S_FAULT);
        fault_cause_o = cause_q;
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage of the RV32I single-cycle core. Owns the program counter, fetches one 32-bit word per instruction from instruction memory over a req/ack handshake, and presents it with its PC to the decode and execute blocks (R/I/S/B/U/J type units) under a valid/ready handshake. Applies branch/jump redirects supplied by the core when an instruction is accepted. Flags fetch faults and halts on them.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset; bits [1:0] must be 0
- IMEM_TIMEOUT, 15, max FETCH cycles waiting for imem_ack before fault; 0 disables the timeout

- clk  in  1  core clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- imem_req  out  1  fetch request, held until ack
- imem_addr  out  32  fetch address (= pc), stable while imem_req=1
- imem_ack  in  1  memory returns imem_rdata this cycle
- imem_rdata  in  32  fetched instruction word
- valid  out  1  idata/pc hold a fetched instruction
- ready  in  1  core accepts instruction this cycle
- idata  out  32  instruction word to decoders
- pc  out  32  address of idata
- branch_taken  in  1  redirect; sampled only on acceptance (valid & ready)
- branch_target  in  32  redirect address
- fault  out  1  sticky fetch fault
- fault_cause  out  2  0 none, 1 timeout, 2 misaligned target, 3 illegal encoding

## Operation
- States: IDLE, FETCH, ISSUE, FAULT. Reset state IDLE.
- IDLE: all handshakes low; next edge -> FETCH.
- FETCH: imem_req=1, imem_addr=pc_reg. On edge with imem_ack=1: ir <= imem_rdata, -> ISSUE. Timeout counter clears on entry, increments each FETCH cycle without ack.
- ISSUE: valid=1, idata=ir, pc=pc_reg. On edge with ready=1: pc_reg <= branch_taken ? branch_target : pc_reg+4; -> FETCH. ready=0: hold idata/pc stable indefinitely.
- Misaligned redirect: acceptance with branch_taken=1 and branch_target[1:0]!=0 -> FAULT, cause 2; pc_reg <= branch_target (reported on pc for debug).
- Timeout: ack accepted in FETCH cycles 1..IMEM_TIMEOUT; no ack by end of cycle IMEM_TIMEOUT -> FAULT, cause 1. Counter width $clog2(IMEM_TIMEOUT+1).
- FAULT: fault=1, valid=0, imem_req=0; exits only via rst.
- pc+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 32'h0).
- imem_ack outside FETCH ignored; imem_rdata ignored when imem_ack=0.
- branch_taken with valid=0 or ready=0 ignored.

## Timing
- Reset values: imem_req=0, imem_addr=RESET_PC, valid=0, idata=0, pc=RESET_PC, fault=0, fault_cause=0; pc_reg=RESET_PC, ir=0, counter=0.
- rst assertion forces outputs to reset values immediately (async), including mid-FETCH with req high; outstanding memory response is then ignored.
- First imem_req: cycle after first rising edge with rst low.
- Zero-wait memory (ack in same cycle as req) and ready=1: one instruction per 2 cycles; valid rises the cycle after the ack edge.
- Acceptance-to-next-req: 1 cycle (next FETCH cycle presents new imem_addr).
- imem_req, imem_addr, valid, idata, pc, fault, fault_cause are functions of registered state only; no combinational path from any input to any output.

## Configuration
- IF_ILLEGAL_CHECK_EN defined: on ack edge, if imem_rdata[1:0]!=2'b11 (not a 32-bit encoding) -> FAULT, cause 3, ir still loaded with the word, valid never asserted for it.
- Undefined: every acked word goes to ISSUE unchecked; fault_cause 3 never produced.

## Test plan
- Reset release, RESET_PC=0, ack on same cycle as req, ready=1: addresses 0x0,0x4,0x8 in consecutive FETCH cycles 2 apart; valid each following cycle with matching idata/pc.
- ready held low 5 cycles in ISSUE, idata=0x00500093: idata/pc stable, imem_req stays 0; ready high -> next req to pc+4.
- Accept with branch_taken=1, target 0x0000_0100 -> next imem_addr=0x100; target 0x0000_0102 -> fault=1, fault_cause=2, valid=0 thereafter.
- IMEM_TIMEOUT=15: ack on FETCH cycle 15 -> normal ISSUE; no ack through cycle 15 -> fault_cause=1 next cycle; ack then ignored.
- pc_reg=0xFFFF_FFFC accepted, no branch -> next imem_addr=0x0000_0000.
- rst pulsed mid-FETCH -> imem_req drops same cycle, pc=RESET_PC; with IF_ILLEGAL_CHECK_EN, ack word 0x00000000 -> fault_cause=3, without it -> valid=1, idata=0.
